// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Double-buffered parallel-in/serial-out shifter; valid/ready word
//            input, one bit per shift_en strobe. Define PISO_PARITY_EN to
//            append a parity bit after the data bits.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter  int DATA_W     = 8,
    parameter  int MSB_FIRST  = 0,
    parameter  int IDLE_LEVEL = 1,
    parameter  int PARITY_ODD = 0,
`ifdef PISO_PARITY_EN
    localparam int c_FRAME_W  = DATA_W + 1,
`else
    localparam int c_FRAME_W  = DATA_W,
`endif
    localparam int c_CNT_W    = $clog2(c_FRAME_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               shift_en,
    output logic               ser_out,
    output logic               busy,
    output logic [c_CNT_W-1:0] bit_cnt,
    output logic               done
);

    localparam logic [0:0]         c_ST_IDLE  = 1'b0;
    localparam logic [0:0]         c_ST_SHIFT = 1'b1;
    localparam logic               c_IDLE_BIT = (IDLE_LEVEL != 0);
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(c_FRAME_W);

    logic [0:0]         r_state;
    logic [DATA_W-1:0]  r_hold;
    logic [DATA_W-1:0]  r_sreg;
    logic               r_hold_full;
    logic               r_ser;
    logic               r_done;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_load;
    logic w_data_bit;
    logic w_next_bit;
    logic w_first_bit;

    // Hold -> shift register transfer: immediately from IDLE, or at the end
    // of the final bit period so consecutive words stream without a gap.
    assign w_load = r_hold_full &&
                    ((r_state == c_ST_IDLE) || (shift_en && (r_cnt == c_LAST)));

    always_comb begin
        w_data_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (r_cnt == c_CNT_W'(i)) begin
                w_data_bit = (MSB_FIRST != 0) ? r_sreg[DATA_W-1-i] : r_sreg[i];
            end
        end
    end

    assign w_first_bit = (MSB_FIRST != 0) ? r_hold[DATA_W-1] : r_hold[0];

`ifdef PISO_PARITY_EN
    logic r_par;
    logic w_hold_par;

    // Parity is latched with the word so it never depends on shifting state.
    assign w_hold_par = (^r_hold) ^ (PARITY_ODD != 0);
    assign w_next_bit = (r_cnt == c_CNT_W'(DATA_W)) ? r_par : w_data_bit;

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_par <= w_hold_par;
        end
    end
`else
    logic w_unused_parity_cfg;

    assign w_unused_parity_cfg = (PARITY_ODD != 0);
    assign w_next_bit          = w_data_bit;
`endif

    always_ff @(posedge clk) begin
        if (in_valid && !r_hold_full) begin
            r_hold <= in_data;
        end
        if (w_load) begin
            r_sreg <= r_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_hold_full <= 1'b0;
            r_ser       <= c_IDLE_BIT;
            r_cnt       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (in_valid && !r_hold_full) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_ser <= c_IDLE_BIT;
                    if (r_hold_full) begin
                        r_state <= c_ST_SHIFT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (shift_en) begin
                        if (r_cnt != c_LAST) begin
                            r_ser <= w_next_bit;
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end else begin
                            r_done <= 1'b1;
                            if (r_hold_full) begin
                                r_ser <= w_first_bit;
                                r_cnt <= c_CNT_W'(1);
                            end else begin
                                r_ser   <= c_IDLE_BIT;
                                r_cnt   <= '0;
                                r_state <= c_ST_IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready = !r_hold_full;
    assign ser_out  = r_ser;
    assign busy     = (r_state == c_ST_SHIFT);
    assign bit_cnt  = r_cnt;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Brief    : Two serializer instances (LSB-first/idle-high/even and
//            MSB-first/idle-low/odd) checked cycle by cycle against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic       shift_en = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic       ser_out0, in_ready0, busy0, done0;
    logic [3:0] bit_cnt0;
    logic       ser_out1, in_ready1, busy1, done1;
    logic [3:0] bit_cnt1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    piso_serializer #(.DATA_W(8), .MSB_FIRST(0), .IDLE_LEVEL(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out0),
        .busy(busy0), .bit_cnt(bit_cnt0), .done(done0)
    );

    piso_serializer #(.DATA_W(8), .MSB_FIRST(1), .IDLE_LEVEL(0), .PARITY_ODD(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out1),
        .busy(busy1), .bit_cnt(bit_cnt1), .done(done1)
    );

    // Reference model: a word becomes a list of frame bits; the model walks it.
    logic       m_active[2];
    logic       m_hold_full[2];
    logic       m_ser[2];
    logic       m_done[2];
    logic [7:0] m_hold[2];
    int         m_pos[2];
    logic       m_bits[2][0:8];

    function automatic logic idle_of(input int k);
        return (k == 0);
    endfunction

    task automatic load_frame(input int k, input logic [7:0] w);
        for (int i = 0; i < 8; i++) m_bits[k][i] = (k == 1) ? w[7-i] : w[i];
        m_bits[k][8] = (^w) ^ (k == 1);
    endtask

    task automatic model_step();
        logic acc;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_active[k] = 0; m_hold_full[k] = 0; m_ser[k] = idle_of(k);
                m_done[k] = 0; m_pos[k] = 0;
            end else begin
                acc = in_valid && !m_hold_full[k];
                m_done[k] = 0;
                if (!m_active[k]) begin
                    m_ser[k] = idle_of(k);
                    if (m_hold_full[k]) begin
                        load_frame(k, m_hold[k]);
                        m_pos[k] = 0; m_active[k] = 1; m_hold_full[k] = 0;
                    end
                end else if (shift_en) begin
                    if (m_pos[k] < FLEN) begin
                        m_ser[k] = m_bits[k][m_pos[k]];
                        m_pos[k]++;
                    end else begin
                        m_done[k] = 1;
                        if (m_hold_full[k]) begin
                            load_frame(k, m_hold[k]);
                            m_ser[k] = m_bits[k][0]; m_pos[k] = 1; m_hold_full[k] = 0;
                        end else begin
                            m_active[k] = 0; m_ser[k] = idle_of(k); m_pos[k] = 0;
                        end
                    end
                end
                if (acc) begin
                    m_hold[k] = in_data; m_hold_full[k] = 1;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_vec(input int k);
        return {m_ser[k], ~m_hold_full[k], m_active[k], m_done[k], 4'(m_pos[k])};
    endfunction

    function automatic logic [7:0] obs(input int k);
        return (k == 0) ? {ser_out0, in_ready0, busy0, done0, bit_cnt0}
                        : {ser_out1, in_ready1, busy1, done1, bit_cnt1};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; shift_en = 0;
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 21; i++) begin
            if (i > 0) tick();
            for (int k = 0; k < 2; k++) begin
                if (obs(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d cyc %0d got %b want %b", k, cyc, obs(k), exp_vec(k));
                end
                checks++;
            end
            if (obs(0) !== 8'b1100_0000 || obs(1) !== 8'b0100_0000) begin
                errors++;
                $display("FAIL reset_idle_const cyc %0d got %b/%b want 11000000/01000000", cyc, obs(0), obs(1));
            end
            checks++;
        end
    endtask

    task automatic test_single();
        logic [7:0] got = '0;
        int prev, n_done = 0;
        shift_en = 1; in_valid = 1; in_data = 8'hA5;
        tick();
        in_valid = 0;
        for (int i = 0; i < FLEN + 4; i++) begin
            prev = m_pos[0];
            tick();
            if (m_pos[0] == prev + 1 && prev < 8) got[7-prev] = ser_out0;
            if (done0) n_done++;
            for (int k = 0; k < 2; k++) begin
                if (obs(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL single dut%0d cyc %0d got %b want %b", k, cyc, obs(k), exp_vec(k));
                end
                checks++;
            end
        end
        if (got !== 8'b1010_0101) begin
            errors++;
            $display("FAIL single_bits got %b want 10100101", got);
        end
        checks++;
        if (n_done != 1 || ser_out0 !== 1'b1) begin
            errors++;
            $display("FAIL single_done done_pulses %0d ser %b want 1 and 1", n_done, ser_out0);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int n_acc = 0, nd = 0;
        int dc[2];
        logic acc;
        shift_en = 1; in_valid = 1; in_data = 8'hA5;
        for (int i = 0; i < 40; i++) begin
            acc = in_valid && !m_hold_full[0];
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc == 1) in_data = 8'h3C;
                if (n_acc == 2) in_valid = 0;
            end
            if (done0) begin
                if (nd < 2) dc[nd] = cyc;
                nd++;
            end
            for (int k = 0; k < 2; k++) begin
                if (obs(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL b2b dut%0d cyc %0d got %b want %b", k, cyc, obs(k), exp_vec(k));
                end
                checks++;
            end
        end
        in_valid = 0;
        if (nd != 2 || dc[1] - dc[0] != FLEN) begin
            errors++;
            $display("FAIL b2b_done pulses %0d spacing %0d want 2 and %0d", nd, dc[1] - dc[0], FLEN);
        end
        checks++;
    endtask

    task automatic test_slow_strobe();
        logic [7:0] got = '0;
        int prev;
        in_data = 8'hA5;
        for (int i = 0; i < 4 * (FLEN + 3) + 4; i++) begin
            in_valid = (i == 0);
            shift_en = (i % 4 == 0);
            prev = m_pos[1];
            tick();
            if (m_pos[1] == prev + 1 && prev < 8) got[7-prev] = ser_out1;
            for (int k = 0; k < 2; k++) begin
                if (obs(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL slow dut%0d cyc %0d got %b want %b", k, cyc, obs(k), exp_vec(k));
                end
                checks++;
            end
        end
        in_valid = 0; shift_en = 0;
        if (got !== 8'b1010_0101) begin
            errors++;
            $display("FAIL slow_msb_bits got %b want 10100101", got);
        end
        checks++;
    endtask

    task automatic test_reset_abort();
        int n_acc = 0;
        logic acc;
        shift_en = 1; in_valid = 1; in_data = 8'hFF;
        for (int i = 0; i < 20 && !(n_acc == 2 && m_pos[0] == 3); i++) begin
            acc = in_valid && !m_hold_full[0];
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc == 1) in_data = 8'h00;
                if (n_acc == 2) in_valid = 0;
            end
        end
        if (n_acc != 2 || bit_cnt0 !== 4'd3) begin
            errors++;
            $display("FAIL abort_setup accepted %0d bit_cnt %0d want 2 and 3", n_acc, bit_cnt0);
        end
        checks++;
        rst = 1;
        tick();
        rst = 0;
        if (ser_out0 !== 1'b1 || in_ready0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got ser %b rdy %b done %b busy %b want 1 1 0 0",
                     ser_out0, in_ready0, done0, busy0);
        end
        checks++;
        for (int i = 0; i < 15; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (obs(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL abort dut%0d cyc %0d got %b want %b", k, cyc, obs(k), exp_vec(k));
                end
                checks++;
            end
            if (ser_out0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet cyc %0d ser %b done %b busy %b want 1 0 0", cyc, ser_out0, done0, busy0);
            end
            checks++;
        end
    endtask

    task automatic test_parity();
        logic [7:0] words[2];
        logic p0, p1;
        int n_done;
        words[0] = 8'hA5; words[1] = 8'h07;
        shift_en = 1;
        for (int w = 0; w < 2; w++) begin
            p0 = 1'bx; p1 = 1'bx; n_done = 0;
            in_valid = 1; in_data = words[w];
            tick();
            in_valid = 0;
            for (int i = 0; i < FLEN + 4; i++) begin
                tick();
                if (m_pos[0] == 9) p0 = ser_out0;
                if (m_pos[1] == 9) p1 = ser_out1;
                if (done0) n_done++;
                for (int k = 0; k < 2; k++) begin
                    if (obs(k) !== exp_vec(k)) begin
                        errors++;
                        $display("FAIL parity dut%0d cyc %0d got %b want %b", k, cyc, obs(k), exp_vec(k));
                    end
                    checks++;
                end
            end
            if (n_done != 1) begin
                errors++;
                $display("FAIL parity_done word %h pulses %0d want 1", words[w], n_done);
            end
            checks++;
`ifdef PISO_PARITY_EN
            if (p0 !== (w == 1) || p1 !== (w == 0)) begin
                errors++;
                $display("FAIL parity_bit word %h got even %b odd %b want %b %b",
                         words[w], p0, p1, (w == 1), (w == 0));
            end
            checks++;
`endif
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = 8'($urandom);
            shift_en = ($urandom_range(0, 3) != 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                if (obs(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got %b want %b", k, cyc, obs(k), exp_vec(k));
                end
                checks++;
            end
        end
        rst = 0; in_valid = 0; shift_en = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_slow_strobe();
        test_reset_abort();
        test_parity();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout after %0d cycles", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
